// File: rtl/regfile_2r1w_clr.sv
// regfile_2r1w_clr: parametrised 2R/1W register file with optional zero entry, write bypass and bulk-clear engine
module regfile_2r1w_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1,
  parameter bit BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wEn,
  input  logic [ADDR_W-1:0] write_sel,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_sel1,
  input  logic [ADDR_W-1:0] read_sel2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] FIRST = ZERO_REG ? ADDR_W'(1) : '0;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic done_q, done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic wr_ok;
  assign wr_ok = wEn && !(ZERO_REG && write_sel == '0);
  // the write port is applied after the clear so it wins a collision at ptr
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    done_d = 1'b0;
    mem_d = mem_q;
    if (state_q == IDLE) begin
      if (clr_req && !done_q) begin
        state_d = CLEAR;
        ptr_d = FIRST;
      end
    end else begin
      mem_d[ptr_q] = '0;
      ptr_d = ptr_q + 1'b1;
      if (&ptr_q) begin
        state_d = IDLE;
        done_d = 1'b1;
        ptr_d = '0;
      end
    end
    if (wr_ok) mem_d[write_sel] = write_data;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      done_q <= done_d;
      mem_q <= mem_d;
    end
  end
  assign read_data1 = (ZERO_REG && read_sel1 == '0) ? '0 :
                      (BYPASS && wEn && read_sel1 == write_sel) ? write_data : mem_q[read_sel1];
  assign read_data2 = (ZERO_REG && read_sel2 == '0) ? '0 :
                      (BYPASS && wEn && read_sel2 == write_sel) ? write_data : mem_q[read_sel2];
  assign clr_busy = state_q == CLEAR;
  assign clr_done = done_q;
endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// tb_regfile_2r1w_clr: directed bench for the default build and a ZERO_REG=0/BYPASS=0 build sharing stimulus
module tb_regfile_2r1w_clr;
  logic clk = 1'b0;
  logic reset, wEn, clr_req;
  logic [4:0] write_sel, read_sel1, read_sel2;
  logic [31:0] write_data;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic a_busy, a_done, b_busy, b_done;
  int n_tot = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  regfile_2r1w_clr dut_a (
    .clock(clk), .reset(reset), .wEn(wEn), .write_sel(write_sel), .write_data(write_data),
    .read_sel1(read_sel1), .read_sel2(read_sel2), .read_data1(a_rd1), .read_data2(a_rd2),
    .clr_req(clr_req), .clr_busy(a_busy), .clr_done(a_done)
  );
  regfile_2r1w_clr #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .clock(clk), .reset(reset), .wEn(wEn), .write_sel(write_sel), .write_data(write_data),
    .read_sel1(read_sel1), .read_sel2(read_sel2), .read_data1(b_rd1), .read_data2(b_rd2),
    .clr_req(clr_req), .clr_busy(b_busy), .clr_done(b_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic wr(input logic [4:0] s, input logic [31:0] d);
    wEn = 1'b1;
    write_sel = s;
    write_data = d;
    cyc();
    wEn = 1'b0;
  endtask
  // counts busy/done cycles of both builds over a fixed window after a clear starts
  task automatic watch_clear(input string tag);
    int ab, bb, ad, bd, a_at;
    ab = 0; bb = 0; ad = 0; bd = 0; a_at = -1;
    for (int k = 0; k < 40; k++) begin
      ab += int'(a_busy);
      bb += int'(b_busy);
      ad += int'(a_done);
      bd += int'(b_done);
      if (a_done && a_at < 0) a_at = k;
      cyc();
    end
    chk({tag, " a busy cycles"}, ab, 31);
    chk({tag, " b busy cycles"}, bb, 32);
    chk({tag, " a done pulses"}, ad, 1);
    chk({tag, " b done pulses"}, bd, 1);
    chk({tag, " a done position"}, a_at, 31);
  endtask
  initial begin
    reset = 1'b0; wEn = 1'b0; clr_req = 1'b0;
    write_sel = '0; write_data = '0; read_sel1 = 5'd5; read_sel2 = 5'd6;
    #12;
    chk("reset rd1", a_rd1, 0);
    chk("reset busy", a_busy, 0);
    chk("reset done", a_done, 0);
    reset = 1'b1;
    cyc();
    wEn = 1'b1; write_sel = 5'd5; write_data = 32'hDEADBEEF; #1;
    chk("t1 a bypass", a_rd1, 32'hDEADBEEF);
    chk("t1 b no bypass", b_rd1, 0);
    cyc();
    wEn = 1'b0; #1;
    chk("t1 a r5", a_rd1, 32'hDEADBEEF);
    chk("t1 b r5", b_rd1, 32'hDEADBEEF);
    chk("t1 a r6", a_rd2, 0);
    read_sel2 = 5'd7; wEn = 1'b1; write_sel = 5'd7; write_data = 32'h1234; #1;
    chk("t2 a bypass", a_rd2, 32'h1234);
    chk("t2 b no bypass", b_rd2, 0);
    cyc();
    wEn = 1'b0; #1;
    chk("t2 a r7", a_rd2, 32'h1234);
    chk("t2 b r7", b_rd2, 32'h1234);
    read_sel1 = 5'd0; wEn = 1'b1; write_sel = 5'd0; write_data = 32'hFFFFFFFF; #1;
    chk("t3 a r0 same", a_rd1, 0);
    chk("t3 b r0 same", b_rd1, 0);
    cyc();
    wEn = 1'b0; #1;
    chk("t3 a r0 next", a_rd1, 0);
    chk("t3 b r0 next", b_rd1, 32'hFFFFFFFF);
    for (int i = 1; i < 32; i++) wr(5'(i), i);
    read_sel1 = 5'd17; read_sel2 = 5'd31; #1;
    chk("t4 a r17", a_rd1, 17);
    chk("t4 b r31", b_rd2, 31);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    watch_clear("t4");
    for (int i = 0; i < 32; i++) begin
      read_sel1 = 5'(i); #1;
      chk($sformatf("t4 a r%0d zero", i), a_rd1, 0);
      chk($sformatf("t4 b r%0d zero", i), b_rd1, 0);
    end
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (5) cyc();
    wr(5'd3, 32'hAA);
    wr(5'd20, 32'hBB);
    wr(5'd8, 32'hCC);
    read_sel1 = 5'd3; #1;
    chk("t5 r3 during clear", a_rd1, 32'hAA);
    repeat (40) cyc();
    chk("t5 a idle", a_busy, 0);
    read_sel1 = 5'd3; read_sel2 = 5'd20; #1;
    chk("t5 a r3", a_rd1, 32'hAA);
    chk("t5 a r20", a_rd2, 0);
    chk("t5 b r3", b_rd1, 32'hAA);
    chk("t5 b r20", b_rd2, 0);
    read_sel1 = 5'd8; #1;
    chk("t5 a r8 at ptr", a_rd1, 32'hCC);
    chk("t5 b r8 ahead", b_rd1, 0);
    wr(5'd25, 32'h55);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (9) cyc();
    chk("t6 busy before reset", a_busy, 1);
    reset = 1'b0; #1;
    read_sel1 = 5'd3; read_sel2 = 5'd25; #1;
    chk("t6 a busy", a_busy, 0);
    chk("t6 b busy", b_busy, 0);
    chk("t6 a r3", a_rd1, 0);
    chk("t6 a r25", a_rd2, 0);
    chk("t6 b r3", b_rd1, 0);
    repeat (3) begin
      cyc();
      chk("t6 no done", a_done | b_done, 0);
    end
    reset = 1'b1;
    cyc();
    chk("t6 no done after release", a_done, 0);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    watch_clear("t6");
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
